// File: rtl/sd_src_switch_ctrl.sv
// sd_src_switch_ctrl
// Hands SD-SPI ownership between the physical SD slot and the HPS-backed
// virtual card. A mount/unmount request is latched at any time. It is only
// committed once the master has deselected the card and the bus has been
// quiet for QUIET_CYCLES clocks. Both targets are then held deselected for
// HOLDOFF_CYCLES, so the CPU sees a clean card swap.
// The block also produces a stretched activity LED and a one-cycle
// media-change pulse.
//
// There is no valid/ready handshake on this block. i_img_mounted is a
// single-cycle strobe that is always accepted. A newer strobe simply
// overwrites the latched target, so the latest event wins.
module sd_src_switch_ctrl #(
  parameter int QUIET_CYCLES   = 1024,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int LED_STRETCH    = 2500000
) (
  input  logic       i_clk_sys,
  input  logic       i_reset_n,
  input  logic       i_img_mounted,
  input  logic       i_img_present,
  input  logic       i_spi_ss,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  input  logic       i_phys_miso,
  input  logic       i_virt_miso,
  output logic       o_spi_miso,
  output logic       o_phys_ss,
  output logic       o_phys_sck,
  output logic       o_phys_mosi,
  output logic       o_virt_ss,
  output logic       o_vsd_sel,
  output logic       o_busy,
  output logic       o_media_change,
  output logic       o_led_act,
  output logic [2:0] o_dbg_state
);

  // Counter widths: $clog2(N) bits are enough to hold N-1, which is the
  // terminal count of each counter.
  localparam int QW = (QUIET_CYCLES   > 1) ? $clog2(QUIET_CYCLES)   : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int LW = (LED_STRETCH    > 1) ? $clog2(LED_STRETCH)    : 1;

  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [LW-1:0] LED_LAST   = LW'(LED_STRETCH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_QUIET   = 3'd2,
    S_SWITCH  = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_vsd_sel;
  logic            r_pending;
  logic            r_target;
  logic            r_media_change;
  logic [QW-1:0]   r_quiet_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_led_act;
  logic [LW-1:0]   r_led_cnt;
  logic            r_sck_q;
  logic            r_mosi_q;
  logic            r_miso_q;

  logic            w_hold;
  logic            w_spi_miso;
  logic            w_act;

  // During holdoff both chip selects are forced high and the master reads
  // an idle (all-ones) MISO line.
  assign w_hold     = (r_state == S_HOLDOFF);
  assign w_spi_miso = w_hold ? 1'b1 : (r_vsd_sel ? i_virt_miso : i_phys_miso);

  assign o_spi_miso  = w_spi_miso;
  assign o_phys_ss   = i_spi_ss | r_vsd_sel | w_hold;
  assign o_phys_sck  = i_spi_sck & ~r_vsd_sel & ~w_hold;
  assign o_phys_mosi = i_spi_mosi & ~r_vsd_sel & ~w_hold;
  assign o_virt_ss   = i_spi_ss | ~r_vsd_sel | w_hold;

  assign o_vsd_sel      = r_vsd_sel;
  assign o_busy         = (r_state != S_IDLE);
  assign o_media_change = r_media_change;
  assign o_led_act      = r_led_act;
  assign o_dbg_state    = r_state;

  // Any edge on sck, mosi or the returned miso counts as bus activity.
  assign w_act = (i_spi_sck  ^ r_sck_q)  |
                 (i_spi_mosi ^ r_mosi_q) |
                 (w_spi_miso ^ r_miso_q);

  // Previous-cycle copies of the SPI lines, used for edge detection.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sck_q  <= 1'b0;
      r_mosi_q <= 1'b0;
      r_miso_q <= 1'b0;
    end else begin
      r_sck_q  <= i_spi_sck;
      r_mosi_q <= i_spi_mosi;
      r_miso_q <= w_spi_miso;
    end
  end

  // Ownership sequencer: wait for a deselected and quiet bus, commit the
  // switch, then hold both targets off. The request latch is updated last,
  // so a strobe in the same cycle as a clear keeps the request alive.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_vsd_sel      <= 1'b0;
      r_pending      <= 1'b0;
      r_target       <= 1'b0;
      r_media_change <= 1'b0;
      r_quiet_cnt    <= '0;
      r_hold_cnt     <= '0;
    end else begin
      r_media_change <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            if (r_target != r_vsd_sel) begin
              r_state <= S_ARMED;
            end else begin
              // The request already matches the current owner, so drop it silently.
              r_pending <= 1'b0;
            end
          end
        end
        S_ARMED: begin
          // Never cut a transaction: wait for the master to deselect.
          if (i_spi_ss) begin
            r_state     <= S_QUIET;
            r_quiet_cnt <= '0;
          end
        end
        S_QUIET: begin
          if (!i_spi_ss || w_act) begin
            r_state <= S_ARMED;
          end else if (r_quiet_cnt == QUIET_LAST) begin
            r_state <= S_SWITCH;
          end else begin
            r_quiet_cnt <= r_quiet_cnt + 1'b1;
          end
        end
        S_SWITCH: begin
          r_vsd_sel      <= r_target;
          r_pending      <= 1'b0;
          r_media_change <= 1'b1;
          r_hold_cnt     <= '0;
          r_state        <= S_HOLDOFF;
        end
        S_HOLDOFF: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (i_img_mounted) begin
        r_target  <= i_img_present;
        r_pending <= 1'b1;
      end
    end
  end

  // Activity LED: retrigger on every edge, then stay lit for LED_STRETCH cycles.
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_led_act <= 1'b0;
      r_led_cnt <= '0;
    end else if (w_act) begin
      r_led_act <= 1'b1;
      r_led_cnt <= LED_LAST;
    end else if (r_led_cnt == '0) begin
      r_led_act <= 1'b0;
    end else begin
      r_led_cnt <= r_led_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_src_switch_ctrl.sv
// Bench for sd_src_switch_ctrl. Each mount that must lead to a switch
// pushes the expected new owner onto exp_q. The media_change monitor pops
// an entry on every pulse and compares it with vsd_sel.
module tb_sd_src_switch_ctrl;

  localparam int Q  = 1024;
  localparam int H  = 64;
  localparam int LS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic img_mounted = 1'b0;
  logic img_present = 1'b0;
  logic spi_ss = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_mosi = 1'b0;
  logic phys_miso = 1'b0;
  logic virt_miso = 1'b0;
  logic spi_miso, phys_ss, phys_sck, phys_mosi, virt_ss;
  logic vsd_sel, busy, mc, led_act;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mc_seen = 0;
  logic mc_prev = 1'b0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_v;

  sd_src_switch_ctrl #(
    .QUIET_CYCLES(Q), .HOLDOFF_CYCLES(H), .LED_STRETCH(LS)
  ) dut (
    .i_clk_sys(clk), .i_reset_n(rst_n),
    .i_img_mounted(img_mounted), .i_img_present(img_present),
    .i_spi_ss(spi_ss), .i_spi_sck(spi_sck), .i_spi_mosi(spi_mosi),
    .i_phys_miso(phys_miso), .i_virt_miso(virt_miso),
    .o_spi_miso(spi_miso), .o_phys_ss(phys_ss), .o_phys_sck(phys_sck),
    .o_phys_mosi(phys_mosi), .o_virt_ss(virt_ss), .o_vsd_sel(vsd_sel),
    .o_busy(busy), .o_media_change(mc), .o_led_act(led_act),
    .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // media_change monitor / scoreboard
  always @(negedge clk) begin
    if (mc === 1'b1) begin
      mc_seen++;
      chk("mc_width", mc_prev, 0);
      chk("mc_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        chk("mc_sel", vsd_sel, exp_v);
      end
    end
    mc_prev = mc;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    img_mounted = 1'b0;
    spi_ss = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic mount(input logic p, output int c0);
    @(negedge clk);
    c0 = cyc;
    img_mounted = 1'b1;
    img_present = p;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic wait_sel(input logic v, input int budget, input string tag, output int at);
    int n;
    n = 0;
    while (vsd_sel !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, vsd_sel, v);
    at = cyc;
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, r, f, t, n, errs, m0;

    // reset state
    do_reset();
    chk("rst_vsd_sel", vsd_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mc", mc, 0);
    chk("rst_led", led_act, 0);
    chk("rst_phys_ss", phys_ss, 1);
    chk("rst_virt_ss", virt_ss, 1);

    // 1: idle bus, mount virtual -> exact latency, then holdoff
    exp_q.push_back(1'b1);
    mount(1'b1, c0);
    wait_sel(1'b1, 3 * Q, "t1", r);
    chk("t1_latency", r - (c0 + 1), Q + 3);
    chk("t1_mc", mc, 1);
    spi_ss = 1'b0;
    n = 0;
    errs = 0;
    while (virt_ss === 1'b1 && n < 4 * H) begin
      if (phys_ss !== 1'b1 || spi_miso !== 1'b1) errs++;
      n++;
      tick(1);
    end
    chk("t1_hold_len", n, H);
    chk("t1_hold_lines", errs, 0);
    chk("t1_busy_after", busy, 0);
    spi_ss = 1'b1;
    tick(4);

    // 2: mount during an active transfer
    do_reset();
    spi_ss = 1'b0;
    exp_q.push_back(1'b1);
    mount(1'b1, c0);
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      spi_sck = ~spi_sck;
      if (vsd_sel !== 1'b0) errs++;
    end
    chk("t2_no_switch", errs, 0);
    chk("t2_busy", busy, 1);
    @(negedge clk);
    c1 = cyc;
    spi_ss = 1'b1;
    wait_sel(1'b1, 3 * Q, "t2", r);
    chk("t2_latency", r - c1, Q + 2);
    tick(H + 4);

    // 3: mosi edge at quiet_cnt==1000 restarts the quiet count
    do_reset();
    exp_q.push_back(1'b1);
    mount(1'b1, c0);
    tick((c0 + 1003) - cyc);
    t = cyc;
    spi_mosi = 1'b1;
    tick((c0 + Q + 4) - cyc);
    chk("t3_no_early", vsd_sel, 0);
    wait_sel(1'b1, 3 * Q, "t3", r);
    chk("t3_latency", r - t, Q + 3);
    tick(H + 4);
    spi_mosi = 1'b0;

    // 4: unmount arrives during holdoff -> switch back, two pulses
    do_reset();
    m0 = mc_seen;
    exp_q.push_back(1'b1);
    mount(1'b1, c0);
    wait_sel(1'b1, 3 * Q, "t4a", r);
    tick(5);
    exp_q.push_back(1'b0);
    mount(1'b0, c1);
    chk("t4_still_virt", vsd_sel, 1);
    wait_sel(1'b0, 3 * Q, "t4b", f);
    chk("t4_back_latency", f - r, H + Q + 3);
    tick(H + 4);
    chk("t4_pulses", mc_seen - m0, 2);

    // 5: mount matching the current owner is dropped
    do_reset();
    m0 = mc_seen;
    mount(1'b0, c0);
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      spi_ss = 1'($urandom_range(0, 1));
      #1;
      if (busy !== 1'b0 || phys_ss !== spi_ss || virt_ss !== 1'b1) errs++;
    end
    chk("t5_routing", errs, 0);
    chk("t5_no_pulse", mc_seen - m0, 0);
    chk("t5_state", dbg_state, 0);
    spi_ss = 1'b1;

    // 6: reset during holdoff
    do_reset();
    exp_q.push_back(1'b1);
    mount(1'b1, c0);
    wait_sel(1'b1, 3 * Q, "t6", r);
    tick(10);
    chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_vsd_sel", vsd_sel, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mc", mc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spi_ss = 1'b0;
    #1;
    chk("t6_phys_ss_lo", phys_ss, 0);
    tick(1);
    spi_ss = 1'b1;
    #1;
    chk("t6_phys_ss_hi", phys_ss, 1);
    tick(Q + 20);
    chk("t6_pending_lost", vsd_sel, 0);

    // 7: single sck edge -> LED stretched for exactly LS cycles
    do_reset();
    tick(3);
    chk("t7_led_off", led_act, 0);
    @(negedge clk);
    spi_sck = 1'b1;
    tick(1);
    n = 0;
    while (led_act === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    chk("t7_led_len", n, LS);
    spi_sck = 1'b0;
    tick(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
